forward_scoreboard: RTL and testbench
=====================================

FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

Interface
REQ-001 Parameter XLEN, default 32, operand/result width.
REQ-002 Parameter AW, default 5, register-address width.
REQ-003 Parameter NSTAGE, default 3 (legal 2..8), in-flight result entries after EX (index 0 = EX/MEM, NSTAGE-1 = last before regfile write).
REQ-004 Parameter NSRC, default 2 (legal 1..4), source-operand read ports.
REQ-005 Parameter LD_IDX, default 1 (legal 0..NSTAGE-1), entry index at which load data arrives.
REQ-006 clock  in  1  single clock; all state changes on rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 pipe_advance  in  1  pipeline moves one stage this cycle.
REQ-009 flush  in  1  kill all in-flight entries.
REQ-010 ex_valid, ex_reg_write  in  1 each  EX instruction valid / writes rd; ex_valid=0 inserts a bubble.
REQ-011 ex_rd  in  AW  EX destination register.
REQ-012 ex_result, ex_result_ready  in  XLEN, 1  EX result, known at end of EX (0 for loads).
REQ-013 ld_data_valid, ld_data  in  1, XLEN  load result for entry[LD_IDX].
REQ-014 src_rs, src_use  in  NSRC*AW, NSRC  packed source registers and use flags for the instruction in EX (slot s at [s*AW +: AW]).
REQ-015 fwd_hit, fwd_data  out  NSRC, NSRC*XLEN  per-source bypass valid and value.
REQ-016 hazard_stall  out  1  some used source depends on a not-yet-ready entry.
REQ-017 stall_count  out  16  cycles with hazard_stall=1 since reset.

Function
REQ-018 Each entry SHALL hold {valid, rd, ready, data}; entries with rd=0 SHALL never be valid.
REQ-019 On pipe_advance (no flush) entry[i] SHALL load entry[i-1] for i=1..NSTAGE-1, entry[0] SHALL load {ex_valid&ex_reg_write&(ex_rd!=0), ex_rd, ex_result_ready, ex_result}; entry[NSTAGE-1] leaving SHALL be discarded.
REQ-020 Without pipe_advance all entries SHALL hold, except load fill.
REQ-021 If ld_data_valid and entry[LD_IDX] valid and not ready, its data SHALL be set to ld_data and ready to 1; with simultaneous pipe_advance the filled value SHALL land in entry[LD_IDX+1] (discarded if LD_IDX=NSTAGE-1).
REQ-022 ld_data_valid with no valid, not-ready entry[LD_IDX] SHALL be ignored.
REQ-023 flush SHALL clear all valid bits at the edge, overriding pipe_advance and load fill.
REQ-024 Lookup is combinational: for each s with src_use[s]=1 and rs!=0, the lowest-index valid entry with rd==rs SHALL be selected (youngest wins).
REQ-025 Selected entry ready: fwd_hit[s]=1, fwd_data slot = entry data.
REQ-026 Selected entry is entry[LD_IDX], not ready, ld_data_valid=1 in the same cycle: fwd_hit[s]=1, fwd_data = ld_data (same-cycle bypass).
REQ-027 Selected entry otherwise not ready: fwd_hit[s]=0, hazard_stall=1; an older ready match SHALL NOT be forwarded instead.
REQ-028 No match, src_use[s]=0, or rs=0: fwd_hit[s]=0, fwd_data slot = 0.
REQ-029 hazard_stall SHALL be the OR over sources of REQ-027.
REQ-030 stall_count SHALL increment by 1 each cycle hazard_stall=1 and saturate at 16'hFFFF; flush SHALL NOT clear it.

Reset
REQ-031 reset=1 at an edge SHALL invalidate all entries and zero stall_count, overriding flush, pipe_advance and load fill.
REQ-032 In the cycle after reset: fwd_hit=0, fwd_data=0, hazard_stall=0, stall_count=0.
REQ-033 Data/rd fields need not reset; only valid/ready bits and stall_count.

Structure
REQ-034 Package forward_pkg SHALL hold the entry struct type and default parameter constants.
REQ-035 Sub-module fwd_match SHALL implement the per-source priority lookup (REQ-024..028), instantiated NSRC times.

Verification
REQ-036 ALU chain: entry[0]={x5,ready,0x11}, entry[1]={x5,ready,0x22}, rs=x5 -> fwd_hit=1, data 0x11.
REQ-037 Load-use: load to x7 enters entry[0] not ready, next cycle EX uses x7 with LD_IDX=1, pipe_advance=0 -> hazard_stall=1, stall_count 0->1; after advance and ld_data_valid=1, ld_data=0xDEAD -> fwd_hit=1, data 0xDEAD, hazard_stall=0.
REQ-038 Fill plus advance: ld_data_valid with pipe_advance -> entry[2] ready with ld_data next cycle.
REQ-039 x0: ex_rd=0, ex_reg_write=1, then rs=0 -> fwd_hit=0, hazard_stall=0.
REQ-040 Flush and reset: valid entries for x3, flush=1 -> next cycle rs=x3 gives fwd_hit=0; reset with flush and pipe_advance -> REQ-032 values.
REQ-041 Saturation: force stall_count to 16'hFFFE, hold hazard for 3 cycles -> reads 16'hFFFF.

Source files
------------

// File: rtl/forward_pkg.sv
// Shared types and default parameter constants for the forwarding scoreboard.
// Each in-flight entry carries a valid/ready status word plus rd and data fields.
package forward_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int AW_DEF     = 5;
    localparam int NSTAGE_DEF = 3;
    localparam int NSRC_DEF   = 2;
    localparam int LD_IDX_DEF = 1;

    typedef struct packed {
        logic valid;
        logic ready;
    } fwd_entry_status_t;

endpackage

// File: rtl/fwd_match.sv
// Per-source priority lookup: the youngest valid entry whose rd matches rs decides
// whether the source is bypassed, bypassed from the arriving load, or stalls.
module fwd_match
    import forward_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int AW     = AW_DEF,
    parameter int NSTAGE = NSTAGE_DEF,
    parameter int LD_IDX = LD_IDX_DEF
) (
    input  logic [NSTAGE-1:0]      ent_valid,
    input  logic [NSTAGE-1:0]      ent_ready,
    input  logic [NSTAGE*AW-1:0]   ent_rd,
    input  logic [NSTAGE*XLEN-1:0] ent_data,
    input  logic [AW-1:0]          rs,
    input  logic                   src_use,
    input  logic                   ld_data_valid,
    input  logic [XLEN-1:0]        ld_data,
    output logic                   hit,
    output logic [XLEN-1:0]        data,
    output logic                   stall
);

    logic            found_s;
    logic            sel_ready_s;
    logic            sel_ld_s;
    logic [XLEN-1:0] sel_data_s;
    logic            match_s;

    // Walk oldest to youngest so the lowest matching index overwrites the selection.
    always_comb begin
        found_s     = 1'b0;
        sel_ready_s = 1'b0;
        sel_ld_s    = 1'b0;
        sel_data_s  = '0;
        match_s     = 1'b0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            match_s     = ent_valid[i] && (ent_rd[i*AW +: AW] == rs);
            found_s     = found_s | match_s;
            sel_ready_s = match_s ? ent_ready[i] : sel_ready_s;
            sel_ld_s    = match_s ? (i == LD_IDX) : sel_ld_s;
            sel_data_s  = match_s ? ent_data[i*XLEN +: XLEN] : sel_data_s;
        end
    end

    // Resolve the selected entry into hit/data/stall; a not-ready youngest match blocks older ones.
    always_comb begin
        hit   = 1'b0;
        data  = '0;
        stall = 1'b0;
        if (src_use && (rs != '0) && found_s) begin
            if (sel_ready_s) begin
                hit  = 1'b1;
                data = sel_data_s;
            end else if (sel_ld_s && ld_data_valid) begin
                hit  = 1'b1;
                data = ld_data;
            end else begin
                stall = 1'b1;
            end
        end else begin
            hit   = 1'b0;
            data  = '0;
            stall = 1'b0;
        end
    end

endmodule

// File: rtl/forward_scoreboard.sv
// Tracks results in flight after EX, fills load data in place, and drives
// per-source bypass values plus a load-use stall with a saturating stall counter.
module forward_scoreboard
    import forward_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int AW     = AW_DEF,
    parameter int NSTAGE = NSTAGE_DEF,
    parameter int NSRC   = NSRC_DEF,
    parameter int LD_IDX = LD_IDX_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 pipe_advance,
    input  logic                 flush,
    input  logic                 ex_valid,
    input  logic                 ex_reg_write,
    input  logic [AW-1:0]        ex_rd,
    input  logic [XLEN-1:0]      ex_result,
    input  logic                 ex_result_ready,
    input  logic                 ld_data_valid,
    input  logic [XLEN-1:0]      ld_data,
    input  logic [NSRC*AW-1:0]   src_rs,
    input  logic [NSRC-1:0]      src_use,
    output logic [NSRC-1:0]      fwd_hit,
    output logic [NSRC*XLEN-1:0] fwd_data,
    output logic                 hazard_stall,
    output logic [15:0]          stall_count
);

    typedef struct packed {
        fwd_entry_status_t st;
        logic [AW-1:0]     rd;
        logic [XLEN-1:0]   data;
    } entry_t;

    entry_t                 entry_q [NSTAGE];
    entry_t                 entry_d [NSTAGE];
    entry_t                 filled_s;
    logic                   fill_s;
    logic [15:0]            stall_count_q;
    logic [15:0]            stall_count_d;
    logic [NSTAGE-1:0]      ent_valid_s;
    logic [NSTAGE-1:0]      ent_ready_s;
    logic [NSTAGE*AW-1:0]   ent_rd_s;
    logic [NSTAGE*XLEN-1:0] ent_data_s;
    logic [NSRC-1:0]        stall_v_s;

    // Next-state of the entry shift chain; the load fill rides along with an advance.
    always_comb begin
        fill_s   = ld_data_valid && entry_q[LD_IDX].st.valid && !entry_q[LD_IDX].st.ready;
        filled_s = entry_q[LD_IDX];
        if (fill_s) begin
            filled_s.st.ready = 1'b1;
            filled_s.data     = ld_data;
        end else begin
            filled_s.st.ready = entry_q[LD_IDX].st.ready;
        end
        entry_d = entry_q;
        if (flush) begin
            for (int i = 0; i < NSTAGE; i++) begin
                entry_d[i].st.valid = 1'b0;
            end
        end else if (pipe_advance) begin
            entry_d[0].st.valid = ex_valid && ex_reg_write && (ex_rd != '0);
            entry_d[0].st.ready = ex_result_ready;
            entry_d[0].rd       = ex_rd;
            entry_d[0].data     = ex_result;
            for (int i = 1; i < NSTAGE; i++) begin
                entry_d[i] = ((i - 1) == LD_IDX) ? filled_s : entry_q[i-1];
            end
        end else begin
            entry_d[LD_IDX] = filled_s;
        end
    end

    // Saturating count of stalled cycles.
    always_comb begin
        if (hazard_stall && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // State registers; only status bits and the counter are reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NSTAGE; i++) begin
                entry_q[i].st <= '0;
            end
            stall_count_q <= 16'd0;
        end else begin
            entry_q       <= entry_d;
            stall_count_q <= stall_count_d;
        end
    end

    // Flatten the entry array for the per-source lookup instances.
    always_comb begin
        for (int i = 0; i < NSTAGE; i++) begin
            ent_valid_s[i]               = entry_q[i].st.valid;
            ent_ready_s[i]               = entry_q[i].st.ready;
            ent_rd_s[i*AW +: AW]         = entry_q[i].rd;
            ent_data_s[i*XLEN +: XLEN]   = entry_q[i].data;
        end
    end

    for (genvar s = 0; s < NSRC; s++) begin : g_src
        fwd_match #(
            .XLEN   (XLEN),
            .AW     (AW),
            .NSTAGE (NSTAGE),
            .LD_IDX (LD_IDX)
        ) u_match (
            .ent_valid     (ent_valid_s),
            .ent_ready     (ent_ready_s),
            .ent_rd        (ent_rd_s),
            .ent_data      (ent_data_s),
            .rs            (src_rs[s*AW +: AW]),
            .src_use       (src_use[s]),
            .ld_data_valid (ld_data_valid),
            .ld_data       (ld_data),
            .hit           (fwd_hit[s]),
            .data          (fwd_data[s*XLEN +: XLEN]),
            .stall         (stall_v_s[s])
        );
    end

    assign hazard_stall = |stall_v_s;
    assign stall_count  = stall_count_q;

endmodule

// File: tb/tb_forward_scoreboard.sv
// Scenario bench for forward_scoreboard: expectations are queued when stimulus is
// applied and popped for comparison once the outputs have settled.
module tb_forward_scoreboard;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NSRC = 2;

    logic                 clock = 1'b0;
    logic                 reset, pipe_advance, flush;
    logic                 ex_valid, ex_reg_write, ex_result_ready, ld_data_valid;
    logic [AW-1:0]        ex_rd;
    logic [XLEN-1:0]      ex_result, ld_data;
    logic [NSRC*AW-1:0]   src_rs;
    logic [NSRC-1:0]      src_use;
    logic [NSRC-1:0]      fwd_hit;
    logic [NSRC*XLEN-1:0] fwd_data;
    logic                 hazard_stall;
    logic [15:0]          stall_count;

    typedef struct {
        string       name;
        logic [1:0]  hit;
        logic [63:0] data;
        logic        stall;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        e;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [15:0] cnt_model = 16'd0;
    logic        exp_stall_now = 1'b0;

    forward_scoreboard #(.XLEN(XLEN), .AW(AW), .NSTAGE(3), .NSRC(NSRC), .LD_IDX(1)) dut (
        .clock(clock), .reset(reset), .pipe_advance(pipe_advance), .flush(flush),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
        .ex_result(ex_result), .ex_result_ready(ex_result_ready),
        .ld_data_valid(ld_data_valid), .ld_data(ld_data),
        .src_rs(src_rs), .src_use(src_use),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .hazard_stall(hazard_stall), .stall_count(stall_count)
    );

    always #5 clock = ~clock;

    task automatic drive(input logic adv, input logic exv, input logic exw, input logic [4:0] rd,
                         input logic [31:0] res, input logic rdy, input logic ldv, input logic [31:0] ldd);
        pipe_advance = adv; ex_valid = exv; ex_reg_write = exw; ex_rd = rd;
        ex_result = res; ex_result_ready = rdy; ld_data_valid = ldv; ld_data = ldd;
    endtask

    task automatic src(input logic [4:0] rs1, input logic [4:0] rs0, input logic [1:0] u);
        src_rs = {rs1, rs0};
        src_use = u;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    // Independent counter model: reset clears, an expected stall cycle counts, saturating.
    task automatic tick();
        @(posedge clock);
        if (reset) cnt_model = 16'd0;
        else if (exp_stall_now && cnt_model != 16'hFFFF) cnt_model = cnt_model + 16'd1;
        exp_stall_now = 1'b0;
        #1;
    endtask

    task automatic expect_out(input string name, input logic [1:0] hit, input logic [31:0] d1,
                              input logic [31:0] d0, input logic stall);
        exp_t x;
        x.name = name; x.hit = hit; x.data = {d1, d0}; x.stall = stall; x.cnt = cnt_model;
        sb_q.push_back(x);
        if (stall) exp_stall_now = 1'b1;
    endtask

    task automatic drain();
        src(5'd0, 5'd0, 2'b00);
        repeat (3) begin
            drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0);
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 5'd3, 32'h3, 1'b1, 1'b1, 32'hAAAA);
        src(5'd0, 5'd0, 2'b00);
        tick(); tick();
        reset = 1'b0; flush = 1'b0; idle(); src(5'd3, 5'd3, 2'b11);
        expect_out("reset_state", 2'b00, 32'h0, 32'h0, 1'b0);
        #1; e = sb_q.pop_front(); n_chk++;
        if ({fwd_hit, fwd_data, hazard_stall, stall_count} !== {e.hit, e.data, e.stall, e.cnt}) begin
            n_fail++; $display("FAIL %s: got hit=%b data=%h stall=%b cnt=%h, want hit=%b data=%h stall=%b cnt=%h", e.name, fwd_hit, fwd_data, hazard_stall, stall_count, e.hit, e.data, e.stall, e.cnt);
        end
    endtask

    task automatic test_alu_chain();
        src(5'd0, 5'd0, 2'b00);
        drive(1'b1, 1'b1, 1'b1, 5'd5, 32'h22, 1'b1, 1'b0, 32'h0); tick();
        drive(1'b1, 1'b1, 1'b1, 5'd5, 32'h11, 1'b1, 1'b0, 32'h0); tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: begin src(5'd5, 5'd5, 2'b01); expect_out("alu_youngest", 2'b01, 32'h0, 32'h11, 1'b0); end
                1: begin src(5'd5, 5'd9, 2'b11); expect_out("alu_slot1", 2'b10, 32'h11, 32'h0, 1'b0); end
                default: begin src(5'd5, 5'd5, 2'b00); expect_out("alu_unused", 2'b00, 32'h0, 32'h0, 1'b0); end
            endcase
            #1; e = sb_q.pop_front(); n_chk++;
            if ({fwd_hit, fwd_data, hazard_stall, stall_count} !== {e.hit, e.data, e.stall, e.cnt}) begin
                n_fail++; $display("FAIL %s: got hit=%b data=%h stall=%b cnt=%h, want hit=%b data=%h stall=%b cnt=%h", e.name, fwd_hit, fwd_data, hazard_stall, stall_count, e.hit, e.data, e.stall, e.cnt);
            end
        end
        for (int k = 0; k < 3; k++) begin
            src(5'd0, 5'd0, 2'b00);
            drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0); tick();
            idle();
            case (k)
                0: begin src(5'd5, 5'd0, 2'b10); expect_out("alu_adv1", 2'b10, 32'h11, 32'h0, 1'b0); end
                1: begin src(5'd0, 5'd5, 2'b01); expect_out("alu_oldest", 2'b01, 32'h0, 32'h11, 1'b0); end
                default: begin src(5'd5, 5'd5, 2'b11); expect_out("alu_drained", 2'b00, 32'h0, 32'h0, 1'b0); end
            endcase
            #1; e = sb_q.pop_front(); n_chk++;
            if ({fwd_hit, fwd_data, hazard_stall, stall_count} !== {e.hit, e.data, e.stall, e.cnt}) begin
                n_fail++; $display("FAIL %s: got hit=%b data=%h stall=%b cnt=%h, want hit=%b data=%h stall=%b cnt=%h", e.name, fwd_hit, fwd_data, hazard_stall, stall_count, e.hit, e.data, e.stall, e.cnt);
            end
        end
    endtask

    task automatic test_load_use();
        src(5'd0, 5'd0, 2'b00);
        drive(1'b1, 1'b1, 1'b1, 5'd7, 32'h0, 1'b0, 1'b0, 32'h0); tick();
        for (int k = 0; k < 5; k++) begin
            case (k)
                0: begin idle(); src(5'd0, 5'd7, 2'b01);
                         expect_out("loaduse_stall", 2'b00, 32'h0, 32'h0, 1'b1); end
                1: begin drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0); src(5'd0, 5'd0, 2'b00);
                         expect_out("loaduse_count", 2'b00, 32'h0, 32'h0, 1'b0); end
                2: begin drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'hDEAD); src(5'd0, 5'd7, 2'b01);
                         expect_out("loaduse_bypass", 2'b01, 32'h0, 32'hDEAD, 1'b0); end
                3: begin drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'hBAD0);
                         expect_out("ld_ignore_ready", 2'b01, 32'h0, 32'hDEAD, 1'b0); end
                default: begin idle();
                         expect_out("loaduse_filled", 2'b01, 32'h0, 32'hDEAD, 1'b0); end
            endcase
            #1; e = sb_q.pop_front(); n_chk++;
            if ({fwd_hit, fwd_data, hazard_stall, stall_count} !== {e.hit, e.data, e.stall, e.cnt}) begin
                n_fail++; $display("FAIL %s: got hit=%b data=%h stall=%b cnt=%h, want hit=%b data=%h stall=%b cnt=%h", e.name, fwd_hit, fwd_data, hazard_stall, stall_count, e.hit, e.data, e.stall, e.cnt);
            end
            tick();
        end
    endtask

    task automatic test_fill_advance();
        drain();
        drive(1'b1, 1'b1, 1'b1, 5'd8, 32'h0, 1'b0, 1'b0, 32'h0); tick();
        drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0); tick();
        for (int k = 0; k < 3; k++) begin
            src(5'd8, 5'd0, 2'b10);
            case (k)
                0: begin drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'hBEEF);
                         expect_out("fill_adv_bypass", 2'b10, 32'hBEEF, 32'h0, 1'b0); end
                1: begin drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h1234);
                         expect_out("fill_adv_landed", 2'b10, 32'hBEEF, 32'h0, 1'b0); end
                default: begin idle();
                         expect_out("ld_ignore_invalid", 2'b10, 32'hBEEF, 32'h0, 1'b0); end
            endcase
            #1; e = sb_q.pop_front(); n_chk++;
            if ({fwd_hit, fwd_data, hazard_stall, stall_count} !== {e.hit, e.data, e.stall, e.cnt}) begin
                n_fail++; $display("FAIL %s: got hit=%b data=%h stall=%b cnt=%h, want hit=%b data=%h stall=%b cnt=%h", e.name, fwd_hit, fwd_data, hazard_stall, stall_count, e.hit, e.data, e.stall, e.cnt);
            end
            tick();
        end
    endtask

    task automatic test_older_blocked();
        drain();
        drive(1'b1, 1'b1, 1'b1, 5'd4, 32'h44, 1'b1, 1'b0, 32'h0); tick();
        drive(1'b1, 1'b1, 1'b1, 5'd4, 32'h0, 1'b0, 1'b0, 32'h0); tick();
        for (int k = 0; k < 2; k++) begin
            src(5'd4, 5'd4, 2'b11);
            if (k == 0) drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h5555);
            else idle();
            expect_out(k == 0 ? "older_blocked_ld" : "older_blocked", 2'b00, 32'h0, 32'h0, 1'b1);
            #1; e = sb_q.pop_front(); n_chk++;
            if ({fwd_hit, fwd_data, hazard_stall, stall_count} !== {e.hit, e.data, e.stall, e.cnt}) begin
                n_fail++; $display("FAIL %s: got hit=%b data=%h stall=%b cnt=%h, want hit=%b data=%h stall=%b cnt=%h", e.name, fwd_hit, fwd_data, hazard_stall, stall_count, e.hit, e.data, e.stall, e.cnt);
            end
            tick();
        end
    endtask

    task automatic test_x0_and_nowrite();
        drain();
        drive(1'b1, 1'b1, 1'b1, 5'd0, 32'h99, 1'b0, 1'b0, 32'h0); tick();
        drive(1'b1, 1'b1, 1'b0, 5'd9, 32'h0, 1'b0, 1'b0, 32'h0); tick();
        idle();
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin src(5'd0, 5'd0, 2'b11); expect_out("x0_source", 2'b00, 32'h0, 32'h0, 1'b0); end
            else begin src(5'd9, 5'd0, 2'b10); expect_out("no_regwrite", 2'b00, 32'h0, 32'h0, 1'b0); end
            #1; e = sb_q.pop_front(); n_chk++;
            if ({fwd_hit, fwd_data, hazard_stall, stall_count} !== {e.hit, e.data, e.stall, e.cnt}) begin
                n_fail++; $display("FAIL %s: got hit=%b data=%h stall=%b cnt=%h, want hit=%b data=%h stall=%b cnt=%h", e.name, fwd_hit, fwd_data, hazard_stall, stall_count, e.hit, e.data, e.stall, e.cnt);
            end
        end
    endtask

    task automatic test_flush();
        drain();
        drive(1'b1, 1'b1, 1'b1, 5'd3, 32'h33, 1'b1, 1'b0, 32'h0); tick();
        drive(1'b1, 1'b1, 1'b1, 5'd3, 32'h0, 1'b0, 1'b0, 32'h0); tick();
        flush = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 5'd3, 32'h77, 1'b1, 1'b1, 32'hDEAD); tick();
        flush = 1'b0; idle(); src(5'd3, 5'd3, 2'b11);
        expect_out("flush_clears", 2'b00, 32'h0, 32'h0, 1'b0);
        #1; e = sb_q.pop_front(); n_chk++;
        if ({fwd_hit, fwd_data, hazard_stall, stall_count} !== {e.hit, e.data, e.stall, e.cnt}) begin
            n_fail++; $display("FAIL %s: got hit=%b data=%h stall=%b cnt=%h, want hit=%b data=%h stall=%b cnt=%h", e.name, fwd_hit, fwd_data, hazard_stall, stall_count, e.hit, e.data, e.stall, e.cnt);
        end
    endtask

    task automatic test_reset_override();
        src(5'd0, 5'd0, 2'b00);
        drive(1'b1, 1'b1, 1'b1, 5'd3, 32'h33, 1'b1, 1'b0, 32'h0); tick();
        reset = 1'b1; flush = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 5'd3, 32'h44, 1'b1, 1'b1, 32'hDEAD); tick();
        reset = 1'b0; flush = 1'b0; idle(); src(5'd3, 5'd3, 2'b11);
        expect_out("reset_override", 2'b00, 32'h0, 32'h0, 1'b0);
        #1; e = sb_q.pop_front(); n_chk++;
        if ({fwd_hit, fwd_data, hazard_stall, stall_count} !== {e.hit, e.data, e.stall, e.cnt}) begin
            n_fail++; $display("FAIL %s: got hit=%b data=%h stall=%b cnt=%h, want hit=%b data=%h stall=%b cnt=%h", e.name, fwd_hit, fwd_data, hazard_stall, stall_count, e.hit, e.data, e.stall, e.cnt);
        end
    endtask

    task automatic test_saturation();
        src(5'd0, 5'd0, 2'b00);
        drive(1'b1, 1'b1, 1'b1, 5'd6, 32'h0, 1'b0, 1'b0, 32'h0); tick();
        idle(); src(5'd0, 5'd6, 2'b01);
        force dut.stall_count_q = 16'hFFFE;
        #1;
        release dut.stall_count_q;
        cnt_model = 16'hFFFE;
        for (int k = 0; k < 4; k++) begin
            expect_out($sformatf("saturation_%0d", k), 2'b00, 32'h0, 32'h0, 1'b1);
            #1; e = sb_q.pop_front(); n_chk++;
            if ({fwd_hit, fwd_data, hazard_stall, stall_count} !== {e.hit, e.data, e.stall, e.cnt}) begin
                n_fail++; $display("FAIL %s: got hit=%b data=%h stall=%b cnt=%h, want hit=%b data=%h stall=%b cnt=%h", e.name, fwd_hit, fwd_data, hazard_stall, stall_count, e.hit, e.data, e.stall, e.cnt);
            end
            tick();
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        idle(); src(5'd0, 5'd0, 2'b00);
        test_reset();
        test_alu_chain();
        test_load_use();
        test_fill_advance();
        test_older_blocked();
        test_x0_and_nowrite();
        test_flush();
        test_reset_override();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
